// File: rtl/kalman_pkg.sv
// Shared definitions for the Kalman front end and core: operand format and launcher state encoding.
package kalman_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 14;
  localparam logic signed [DATA_W-1:0] ONE_Q14 = 16'sd16384;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_START = 2'd1,
    L_WAIT  = 2'd2
  } launch_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/kalman_avg_window.sv
// Block averager: sums 2^AVG_LOG2 signed samples per channel and emits the floored mean
// with a one-cycle valid.
module kalman_avg_window
  import kalman_pkg::*;
#(
  parameter int DATA_W   = kalman_pkg::DATA_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_theta,
  input  logic signed [DATA_W-1:0] i_phi,
  output logic                     o_mean_valid,
  output logic signed [DATA_W-1:0] o_mean_theta,
  output logic signed [DATA_W-1:0] o_mean_phi
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

  logic signed [ACC_W-1:0] r_acc_theta;
  logic signed [ACC_W-1:0] r_acc_phi;
  logic        [CNT_W-1:0] r_cnt;
  logic signed [ACC_W-1:0] w_sum_theta;
  logic signed [ACC_W-1:0] w_sum_phi;
  logic                    w_last;

  // Size casts of signed operands sign-extend, so the sum cannot overflow.
  assign w_sum_theta = r_acc_theta + ACC_W'(i_theta);
  assign w_sum_phi   = r_acc_phi + ACC_W'(i_phi);
  assign w_last      = (r_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_theta  <= '0;
      r_acc_phi    <= '0;
      r_cnt        <= '0;
      o_mean_valid <= 1'b0;
      o_mean_theta <= '0;
      o_mean_phi   <= '0;
    end else if (i_clear) begin
      r_acc_theta  <= '0;
      r_acc_phi    <= '0;
      r_cnt        <= '0;
      o_mean_valid <= 1'b0;
    end else begin
      o_mean_valid <= 1'b0;
      if (i_valid) begin
        if (w_last) begin
          r_acc_theta  <= '0;
          r_acc_phi    <= '0;
          r_cnt        <= '0;
          o_mean_theta <= DATA_W'(w_sum_theta >>> AVG_LOG2);
          o_mean_phi   <= DATA_W'(w_sum_phi >>> AVG_LOG2);
          o_mean_valid <= 1'b1;
        end else begin
          r_acc_theta <= w_sum_theta;
          r_acc_phi   <= w_sum_phi;
          r_cnt       <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kalman_meas_feeder.sv
// Averages angle samples into window means and launches the Kalman core on each one,
// holding operands stable until the core's finish edge or a timeout.
//
// state   | meaning
// L_IDLE  | no transaction; launch when a pending mean exists and enable is high
// L_START | kf_start pulse cycle; operands just loaded
// L_WAIT  | waiting for a kf_finish rising edge or timeout
module kalman_meas_feeder
  import kalman_pkg::*;
#(
  parameter int DATA_W   = kalman_pkg::DATA_W,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_theta,
  input  logic [DATA_W-1:0] s_phi,
  output logic              s_ready,
  output logic [DATA_W-1:0] kf_theta_acc,
  output logic [DATA_W-1:0] kf_phi_acc,
  output logic              kf_start,
  input  logic              kf_finish,
  output logic              busy,
  output logic [7:0]        overrun_cnt,
  output logic              timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);

  launch_state_t r_state;
  launch_state_t w_state_nxt;

  logic              w_mean_valid;
  logic [DATA_W-1:0] w_mean_theta;
  logic [DATA_W-1:0] w_mean_phi;
  logic              r_pend_valid;
  logic [DATA_W-1:0] r_pend_theta;
  logic [DATA_W-1:0] r_pend_phi;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_finish_q;
  logic              w_finish_rise;
  logic              w_launch;
  logic              w_timeout;
  logic [7:0]        r_overrun_cnt;
  logic              r_timeout_err;
  logic [DATA_W-1:0] r_op_theta;
  logic [DATA_W-1:0] r_op_phi;

  kalman_avg_window #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (!enable),
    .i_valid     (s_valid && enable),
    .i_theta     ($signed(s_theta)),
    .i_phi       ($signed(s_phi)),
    .o_mean_valid(w_mean_valid),
    .o_mean_theta(w_mean_theta),
    .o_mean_phi  (w_mean_phi)
  );

  assign s_ready       = enable;
  assign w_finish_rise = kf_finish && !r_finish_q;
  assign w_wait_inc    = r_wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= L_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A finish edge is tested before the timeout so a coincident finish is not an error.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      L_IDLE: begin
        if (r_pend_valid && enable) begin
          w_launch    = 1'b1;
          w_state_nxt = L_START;
        end
      end
      L_START: w_state_nxt = L_WAIT;
      L_WAIT: begin
        if (w_finish_rise) begin
          w_state_nxt = L_IDLE;
        end else if (w_wait_inc == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = L_IDLE;
        end
      end
      default: w_state_nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_finish_q <= 1'b0;
    end else begin
      r_finish_q <= kf_finish;
      if (r_state == L_START)     r_wait_cnt <= '0;
      else if (r_state == L_WAIT) r_wait_cnt <= w_wait_inc;
    end
  end

  // Single-entry buffer: a fresh mean overwrites an unconsumed one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_theta  <= '0;
      r_pend_phi    <= '0;
      r_overrun_cnt <= '0;
    end else if (!enable) begin
      r_pend_valid <= 1'b0;
    end else if (w_mean_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_theta <= w_mean_theta;
      r_pend_phi   <= w_mean_phi;
      if (r_pend_valid && !w_launch) r_overrun_cnt <= sat_inc8(r_overrun_cnt);
    end else if (w_launch) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_theta    <= '0;
      r_op_phi      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_launch) begin
        r_op_theta <= r_pend_theta;
        r_op_phi   <= r_pend_phi;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign kf_theta_acc = r_op_theta;
  assign kf_phi_acc   = r_op_phi;
  assign kf_start     = (r_state == L_START);
  assign busy         = (r_state != L_IDLE);
  assign overrun_cnt  = r_overrun_cnt;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_kalman_meas_feeder.sv
// Bench for kalman_meas_feeder: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model of window means, the pending slot and the launch timing.
module tb_kalman_meas_feeder;

  localparam int DW = 16;
  localparam int AL = 2;
  localparam int TO = 64;
  localparam int NS = 1 << AL;

  logic          clk = 1'b0;
  logic          reset, enable, s_valid, kf_finish;
  logic [DW-1:0] s_theta, s_phi;
  logic          s_ready, kf_start, busy, timeout_err;
  logic [DW-1:0] kf_theta_acc, kf_phi_acc;
  logic [7:0]    overrun_cnt;

  always #5 clk = ~clk;

  kalman_meas_feeder #(.DATA_W(DW), .AVG_LOG2(AL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid),
    .s_theta(s_theta), .s_phi(s_phi), .s_ready(s_ready),
    .kf_theta_acc(kf_theta_acc), .kf_phi_acc(kf_phi_acc), .kf_start(kf_start),
    .kf_finish(kf_finish), .busy(busy), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: samples collected in queues, means by floor division,
  // launcher tracked as "busy" plus cycles elapsed since the start pulse.
  int q_th[$];
  int q_ph[$];
  bit st_v;  int st_th, st_ph;
  bit pd_v;  int pd_th, pd_ph;
  bit m_busy, m_start, m_err, m_fin_q;
  int m_el, m_ovr, m_op_th, m_op_ph;

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q--;
    return q;
  endfunction

  task automatic model_reset();
    q_th.delete(); q_ph.delete();
    st_v = 0; st_th = 0; st_ph = 0;
    pd_v = 0; pd_th = 0; pd_ph = 0;
    m_busy = 0; m_start = 0; m_err = 0; m_fin_q = 0;
    m_el = 0; m_ovr = 0; m_op_th = 0; m_op_ph = 0;
  endtask

  task automatic model_step(input bit rst, input bit en, input bit vld,
                            input int th, input int ph, input bit fin);
    bit rise, consumed;
    int sth, sph;
    if (rst) begin
      model_reset();
      return;
    end
    rise     = fin && !m_fin_q;
    consumed = 0;
    if (!m_busy) begin
      if (pd_v && en) begin
        m_op_th = pd_th; m_op_ph = pd_ph;
        m_start = 1; m_busy = 1; m_el = 0; consumed = 1;
      end
    end else if (m_start) begin
      m_start = 0; m_el = 1;
    end else if (rise) begin
      m_busy = 0;
    end else if (m_el + 1 == TO) begin
      m_err = 1; m_busy = 0;
    end else begin
      m_el++;
    end
    if (!en) pd_v = 0;
    else if (st_v) begin
      if (pd_v && !consumed && m_ovr < 255) m_ovr++;
      pd_v = 1; pd_th = st_th; pd_ph = st_ph;
    end else if (consumed) pd_v = 0;
    st_v = 0;
    if (!en) begin
      q_th.delete(); q_ph.delete();
    end else if (vld) begin
      q_th.push_back(th); q_ph.push_back(ph);
      if (q_th.size() == NS) begin
        sth = 0; sph = 0;
        foreach (q_th[i]) begin sth += q_th[i]; sph += q_ph[i]; end
        st_th = floor_div(sth, NS); st_ph = floor_div(sph, NS); st_v = 1;
        q_th.delete(); q_ph.delete();
      end
    end
    m_fin_q = fin;
  endtask

  task automatic compare_all();
    check_val("kf_start", int'(kf_start), int'(m_start));
    check_val("busy", int'(busy), int'(m_busy));
    check_val("theta_acc", int'($signed(kf_theta_acc)), m_op_th);
    check_val("phi_acc", int'($signed(kf_phi_acc)), m_op_ph);
    check_val("overrun_cnt", int'(overrun_cnt), m_ovr);
    check_val("timeout_err", int'(timeout_err), int'(m_err));
  endtask

  task automatic tick(input bit rst, input bit en, input bit vld,
                      input int th, input int ph, input bit fin);
    reset = rst; enable = en; s_valid = vld;
    s_theta = DW'(th); s_phi = DW'(ph); kf_finish = fin;
    #1;
    check_val("s_ready", int'(s_ready), int'(en));
    model_step(rst, en, vld, th, ph, fin);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    bit fin_r;
    reset = 1; enable = 0; s_valid = 0; s_theta = '0; s_phi = '0; kf_finish = 0;
    model_reset();
    @(negedge clk);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    check_val("rst_start", int'(kf_start), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_theta", int'(kf_theta_acc), 0);
    check_val("rst_ovr", int'(overrun_cnt), 0);

    // Scenario 1: basic window with floor rounding on the negative channel
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 100 * (i + 1), -(i + 1), 0);
    tick(0, 1, 0, 0, 0, 0);
    check_val("t1_no_early_start", int'(kf_start), 0);
    tick(0, 1, 0, 0, 0, 0);
    check_val("t1_start", int'(kf_start), 1);
    check_val("t1_theta", int'($signed(kf_theta_acc)), 250);
    check_val("t1_phi", int'($signed(kf_phi_acc)), -3);

    // Scenario 2: finish 30 cycles after start, second window queued meanwhile
    for (int n = 1; n <= 45; n++) begin
      tick(0, 1, (n >= 2 && n <= 5), 40, 8, (n >= 30 && n < 33) || (n >= 40 && n < 42));
      if (n < 30) check_val("t2_hold_theta", int'($signed(kf_theta_acc)), 250);
      if (n < 30) check_val("t2_hold_phi", int'($signed(kf_phi_acc)), -3);
      if (n == 30) check_val("t2_busy_drop", int'(busy), 0);
      if (n == 31) check_val("t2_relaunch", int'(kf_start), 1);
      if (n == 31) check_val("t2_theta2", int'($signed(kf_theta_acc)), 40);
    end

    // Scenario 3: core never finishes
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 1000, -1000 + i, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    check_val("t3_start", int'(kf_start), 1);
    for (int n = 1; n <= 80; n++) begin
      tick(0, 1, (n >= 5 && n <= 8), -7, 3, (n >= 70));
      if (n == 63) check_val("t3_err_pre", int'(timeout_err), 0);
      if (n == 64) check_val("t3_err", int'(timeout_err), 1);
      if (n == 64) check_val("t3_busy", int'(busy), 0);
      if (n == 65) check_val("t3_next_start", int'(kf_start), 1);
      if (n == 65) check_val("t3_next_theta", int'($signed(kf_theta_acc)), -7);
    end
    check_val("t3_err_sticky", int'(timeout_err), 1);

    // Scenario 4: three windows during one wait, then saturation
    tick(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 1, 11, 22, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    for (int n = 1; n <= 21; n++) begin
      if (n <= 8)       tick(0, 1, 1, rnd16(), rnd16(), 0);
      else if (n <= 12) tick(0, 1, 1, 7, -9, 0);
      else              tick(0, 1, 0, 0, 0, (n == 20));
      if (n == 20) check_val("t4_ovr2", int'(overrun_cnt), 2);
      if (n == 21) check_val("t4_start", int'(kf_start), 1);
      if (n == 21) check_val("t4_theta", int'($signed(kf_theta_acc)), 7);
      if (n == 21) check_val("t4_phi", int'($signed(kf_phi_acc)), -9);
    end
    for (int n = 0; n < 1400; n++) tick(0, 1, 1, rnd16(), rnd16(), 0);
    check_val("t4_ovr_sat", int'(overrun_cnt), 255);

    // Scenario 5: enable drop discards the partial window
    tick(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 5000, -5000, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, rnd16(), rnd16(), 0);
      check_val("t5_ready_low", int'(s_ready), 0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1, 8, 8, 0);
      check_val("t5_no_launch", int'(kf_start), 0);
    end
    tick(0, 1, 0, 0, 0, 0);
    check_val("t5_no_launch", int'(kf_start), 0);
    tick(0, 1, 0, 0, 0, 0);
    check_val("t5_start", int'(kf_start), 1);
    check_val("t5_theta", int'($signed(kf_theta_acc)), 8);
    check_val("t5_phi", int'($signed(kf_phi_acc)), 8);

    // Scenario 6: reset during wait with a coincident finish edge
    for (int n = 0; n < 5; n++) tick(0, 1, 0, 0, 0, 0);
    check_val("t6_in_wait", int'(busy), 1);
    tick(1, 1, 0, 0, 0, 1);
    check_val("t6_start", int'(kf_start), 0);
    check_val("t6_busy", int'(busy), 0);
    check_val("t6_theta", int'(kf_theta_acc), 0);
    check_val("t6_err", int'(timeout_err), 0);
    tick(0, 1, 0, 0, 0, 1);
    check_val("t6_after_start", int'(kf_start), 0);
    check_val("t6_after_busy", int'(busy), 0);

    // Random traffic with a randomly toggling finish line
    fin_r = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) fin_r = !fin_r;
      tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 9) < 7), rnd16(), rnd16(), fin_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
